// File: rtl/product_accumulator.sv
// product_accumulator: accumulates a programmed number of 8-bit products from
// the array multiplier into an ACC_WIDTH-bit sum. The sum wraps modulo
// 2^ACC_WIDTH, and a sticky overflow flag records any carry out during the job.
//
// Handshakes: a transfer on either port happens on a rising edge where both
// valid and ready are high. Neither ready depends combinationally on its valid:
// in_ready, out_valid and busy decode purely from the registered state. Once
// out_valid is high, out_sum and out_overflow do not change until out_ready is
// seen.
//
// State encoding, visible on dbg_state: IDLE=0, ACCUM=1, DONE=2.

module product_accumulator #(
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_overflow,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   overflow;
  logic [COUNT_WIDTH-1:0] remaining;

  logic                   in_fire;
  logic                   out_fire;
  logic                   job_start;
  logic                   last_product;
  logic [ACC_WIDTH:0]     sum_ext;

  // One extra bit on the adder captures the carry out of ACC_WIDTH.
  assign sum_ext      = {1'b0, acc} + (ACC_WIDTH + 1)'(in_product);
  assign in_fire      = (state == ACCUM) && in_valid;
  assign out_fire     = (state == DONE) && out_ready;
  // A job starts from IDLE, or from DONE in the same cycle the result leaves.
  assign job_start    = start && ((state == IDLE) || out_fire);
  assign last_product = in_fire && (remaining == COUNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_product) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_fire) begin
          if (start) begin
            state_next = (len == '0) ? DONE : ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: clear on job start, add one product per input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
    end else if (job_start) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= len;
    end else if (in_fire) begin
      acc       <= sum_ext[ACC_WIDTH-1:0];
      overflow  <= overflow | sum_ext[ACC_WIDTH];
      remaining <= remaining - COUNT_WIDTH'(1);
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_sum      = acc;
    out_overflow = overflow;
    dbg_state    = state;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances share one stimulus stream: a
// 16-bit accumulator (default) and an 8-bit one, so wrap-around and overflow
// are observable. Their handshake timing is width-independent, so the driver
// follows the wide instance's ready/busy signals.
// The reference model is the plain integer sum of each job's products; the
// expected wide/narrow results are that sum modulo 2^W, with overflow set
// when the sum reaches 2^W.

module tb_product_accumulator;

  localparam int CW    = 4;
  localparam int WW    = 16;
  localparam int NW    = 8;
  localparam logic [1:0] IDLE_ENC = 2'd0;

  // Clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_product = '0;
  logic          out_ready = 1'b0;

  logic          w_in_ready, w_out_valid, w_out_ovf, w_busy;
  logic [WW-1:0] w_out_sum;
  logic [1:0]    w_dbg;
  logic          n_in_ready, n_out_valid, n_out_ovf, n_busy;
  logic [NW-1:0] n_out_sum;
  logic [1:0]    n_dbg;

  product_accumulator #(.ACC_WIDTH(WW), .COUNT_WIDTH(CW)) u_dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_product(in_product),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum),
    .out_overflow(w_out_ovf), .busy(w_busy), .dbg_state(w_dbg)
  );

  product_accumulator #(.ACC_WIDTH(NW), .COUNT_WIDTH(CW)) u_dut_n (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_product(in_product),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_overflow(n_out_ovf), .busy(n_busy), .dbg_state(n_dbg)
  );

  // Scoreboard state
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_n_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_w_q.delete();
    exp_n_q.delete();
    check("rst_in_ready",  32'(w_in_ready),  0);
    check("rst_out_valid", 32'(w_out_valid), 0);
    check("rst_out_sum",   32'(w_out_sum),   0);
    check("rst_out_ovf",   32'(w_out_ovf),   0);
    check("rst_busy",      32'(w_busy),      0);
    check("rst_state",     32'(w_dbg),       32'(IDLE_ENC));
    check("rst_n_out_sum", 32'(n_out_sum),   0);
    check("rst_n_busy",    32'(n_busy),      0);
  endtask

  // Issue start (held until the DUT takes it) and record the expected sum.
  task automatic start_job(input int l, input logic [31:0] s);
    bit taken;
    exp_w_q.push_back(s);
    exp_n_q.push_back(s);
    start = 1'b1;
    len = CW'(l);
    taken = 1'b0;
    for (int i = 0; i < 200 && !taken; i++) begin
      if (w_out_valid) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      else out_ready = 1'b0;
      taken = !w_busy || (w_out_valid && out_ready);
      step();
    end
    start = 1'b0;
    out_ready = 1'b0;
    len = CW'($urandom_range(0, 15));
    if (!taken) timeout("start_accept");
  endtask

  task automatic feed(input int p, input int gap_max);
    bit taken;
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) begin
        in_product = 8'($urandom);
        step();
      end
    end
    in_valid = 1'b1;
    in_product = 8'(p);
    taken = 1'b0;
    for (int i = 0; i < 200 && !taken; i++) begin
      taken = w_in_ready;
      step();
    end
    if (!taken) timeout("product_accept");
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && w_busy; i++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    out_ready = 1'b0;
    if (w_busy) timeout("drain");
  endtask

  task automatic run_random_job(input int gap_max);
    int l;
    int prods[$];
    logic [31:0] s;
    l = int'($urandom_range(0, 15));
    s = 0;
    for (int i = 0; i < l; i++) begin
      prods.push_back(int'($urandom_range(0, 255)));
      s = s + 32'(prods[i]);
    end
    start_job(l, s);
    foreach (prods[i]) feed(prods[i], gap_max);
    in_valid = 1'b0;
  endtask

  // Monitor: wide instance, pops on every output transfer
  logic [31:0]   w_e;
  bit            w_hold = 1'b0;
  logic [WW-1:0] w_hold_sum;
  always @(negedge clk) begin
    if (!rst) begin
      if (w_hold) check("w_hold_sum", 32'(w_out_sum), 32'(w_hold_sum));
      if (w_out_valid && out_ready) begin
        if (exp_w_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL w_unexpected: got sum %0d, expected no result", w_out_sum);
        end else begin
          w_e = exp_w_q.pop_front();
          check("w_sum", 32'(w_out_sum), w_e % 32'h1_0000);
          check("w_ovf", 32'(w_out_ovf), 32'(w_e >= 32'h1_0000));
        end
      end
      w_hold = w_out_valid && !out_ready;
      w_hold_sum = w_out_sum;
    end else begin
      w_hold = 1'b0;
    end
  end

  // Monitor: narrow instance
  logic [31:0] n_e;
  always @(negedge clk) begin
    if (!rst && n_out_valid && out_ready) begin
      if (exp_n_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL n_unexpected: got sum %0d, expected no result", n_out_sum);
      end else begin
        n_e = exp_n_q.pop_front();
        check("n_sum", 32'(n_out_sum), n_e % 32'd256);
        check("n_ovf", 32'(n_out_ovf), 32'(n_e >= 32'd256));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    do_reset();

    // Nominal: three 225 products back to back
    start_job(3, 675);
    for (int i = 0; i < 3; i++) begin
      check("nom_in_ready", 32'(w_in_ready), 1);
      feed(225, 0);
    end
    in_valid = 1'b0;
    check("nom_latency_valid", 32'(w_out_valid), 1);
    check("nom_sum_visible", 32'(w_out_sum), 675);
    drain();

    // Overflow on the 8-bit instance, then a clean job clears it
    start_job(2, 300);
    feed(200, 0);
    feed(100, 0);
    drain();
    start_job(1, 5);
    feed(5, 0);
    drain();

    // Input gaps and output back-pressure with ignored start pulses
    start_job(2, 15);
    check("stall_in_ready", 32'(w_in_ready), 1);
    in_valid = 1'b1;
    in_product = 8'd6;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_product = 8'($urandom);
      step();
    end
    check("stall_gap_sum", 32'(w_out_sum), 6);
    check("stall_gap_ready", 32'(w_in_ready), 1);
    in_valid = 1'b1;
    in_product = 8'd9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'(i % 2);
      len = CW'($urandom_range(0, 15));
      out_ready = 1'b0;
      check("stall_out_valid", 32'(w_out_valid), 1);
      check("stall_out_sum", 32'(w_out_sum), 15);
      check("stall_in_ready_low", 32'(w_in_ready), 0);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_idle_busy", 32'(w_busy), 0);
    check("stall_idle_valid", 32'(w_out_valid), 0);

    // Empty job
    start_job(0, 0);
    check("empty_valid", 32'(w_out_valid), 1);
    check("empty_sum", 32'(w_out_sum), 0);
    check("empty_ovf", 32'(w_out_ovf), 0);
    drain();

    // Reset in the middle of a job discards it
    start_job(4, 0);
    feed(50, 0);
    feed(70, 0);
    in_valid = 1'b0;
    check("midjob_partial", 32'(w_out_sum), 120);
    do_reset();
    start_job(1, 9);
    feed(9, 0);
    drain();

    // Back-to-back: new start in the same cycle as the output transfer
    start_job(2, 120);
    feed(60, 0);
    feed(60, 0);
    in_valid = 1'b0;
    check("b2b_done_valid", 32'(w_out_valid), 1);
    check("b2b_done_sum", 32'(w_out_sum), 120);
    exp_w_q.push_back(3);
    exp_n_q.push_back(3);
    out_ready = 1'b1;
    start = 1'b1;
    len = CW'(2);
    step();
    start = 1'b0;
    out_ready = 1'b0;
    check("b2b_in_ready", 32'(w_in_ready), 1);
    check("b2b_busy", 32'(w_busy), 1);
    check("b2b_acc_clear", 32'(w_out_sum), 0);
    feed(1, 0);
    feed(2, 0);
    drain();

    // Randomized jobs with input gaps and random output back-pressure
    rand_ready = 1'b1;
    for (int j = 0; j < 40; j++) run_random_job(2);
    drain();
    step();
    check("queue_w_empty", 32'(exp_w_q.size()), 0);
    check("queue_n_empty", 32'(exp_n_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
